fetch_pc_unit: RTL and testbench

// - Owns the program counter. Fetches each instruction over a req/gnt/rvalid memory port and holds it for execute.
// - On exec_done, computes next PC from the branch decoder's taken bit plus the jal/jalr decode. Then starts the next fetch.
// - Sits directly upstream of branch resolution. Consumes taken; produces pc, pc_plus4 and instr for decode/execute.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/next_pc_calc.sv | 33 +++
 rtl/fetch_pc_unit.sv | 109 ++++++++++
 tb/tb_fetch_pc_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/PC slice of the core.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_EXEC,
    S_HALT
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the instruction held in execute.
// Priority: jalr, then jal, then taken conditional branch, else sequential.
module next_pc_calc (
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  input  logic        taken,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] jalr_target;

  assign jalr_target = rs1_val + imm;

  // Pick the target by decode priority; all sums wrap modulo 2^32.
  always_comb begin
    next_pc = pc + 32'd4;
    if (is_jalr) begin
      next_pc = {jalr_target[31:1], 1'b0};
    end else if (is_jal) begin
      next_pc = pc + imm;
    end else if (is_branch && taken) begin
      next_pc = pc + imm;
    end
  end

  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter owner: fetches one instruction at a time over the
// req/gnt/rvalid port, holds it for execute, then steers to the next PC.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = cpu_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic        taken,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  output logic        misalign
);

  import cpu_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  next_pc;
  logic         next_misaligned;

  next_pc_calc u_next_pc_calc (
    .pc         (pc_q),
    .imm        (imm),
    .rs1_val    (rs1_val),
    .taken      (taken),
    .is_branch  (is_branch),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .next_pc    (next_pc),
    .misaligned (next_misaligned)
  );

  // State, PC and instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Fetch sequencing and PC update; rvalid only matters in S_REQ (with gnt) and S_WAIT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            state_d = S_EXEC;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          instr_d = NOP_INSTR;
          if (next_misaligned) begin
            state_d = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  // Valid and sticky-misalign flags are pure functions of the registered state.
  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_EXEC);
  assign misalign    = (state_q == S_HALT);
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: stimulus pushes expected fetch
// addresses and delivered instructions; monitors pop and compare.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_done;
  logic        taken;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic        misalign;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_fetch[$];
  logic [63:0] exp_instr[$];
  logic [31:0] mem [logic [31:0]];

  int gnt_lat = 0;
  int rv_lat  = 0;

  fetch_pc_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .exec_done   (exec_done),
    .taken       (taken),
    .is_branch   (is_branch),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .imm         (imm),
    .rs1_val     (rs1_val),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[23:0], 8'h13};
  endfunction

  // Memory responder: grant after gnt_lat req cycles, data rv_lat cycles after grant.
  initial begin : responder
    int          reqcnt;
    int          pcnt;
    bit          pending;
    logic [31:0] pdata;
    reqcnt = 0; pcnt = 0; pending = 0; pdata = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (pending) begin
        if (pcnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pdata;
          pending     = 0;
        end else begin
          pcnt--;
        end
      end else if (!rst_n) begin
        reqcnt = 0;
      end else if (imem_req) begin
        if (reqcnt >= gnt_lat) begin
          imem_gnt = 1'b1;
          reqcnt   = 0;
          if (rv_lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mread(imem_addr);
          end else begin
            pending = 1;
            pcnt    = rv_lat - 1;
            pdata   = mread(imem_addr);
          end
        end else begin
          reqcnt++;
        end
      end
    end
  end

  // Monitor: fetch addresses, request stability, delivered instructions.
  initial begin : monitor
    logic        prev_valid;
    logic        prev_rvalid;
    logic        prev_req;
    logic [31:0] prev_addr;
    logic [31:0] a;
    logic [63:0] e;
    prev_valid = 1'b0; prev_rvalid = 1'b0; prev_req = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid  = 1'b0;
        prev_rvalid = 1'b0;
        prev_req    = 1'b0;
      end else begin
        if (imem_req && imem_gnt) begin
          if (exp_fetch.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
          end else begin
            a = exp_fetch.pop_front();
            chk("fetch_addr", imem_addr, a);
          end
        end
        if (imem_req && prev_req) chk("addr_stable", imem_addr, prev_addr);
        if (imem_req) chk("no_valid_during_req", {31'd0, instr_valid}, 32'd0);
        if (instr_valid && !prev_valid) begin
          chk("rvalid_before_valid", {31'd0, prev_rvalid}, 32'd1);
          if (exp_instr.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL instr_unexpected: got pc %h expected no instruction", pc);
          end else begin
            e = exp_instr.pop_front();
            chk("instr_pc", pc, e[63:32]);
            chk("instr_word", instr, e[31:0]);
            chk("pc_plus4", pc_plus4, e[63:32] + 32'd4);
          end
        end
        prev_valid  = instr_valid;
        prev_rvalid = imem_rvalid;
        prev_req    = imem_req;
        prev_addr   = imem_addr;
      end
    end
  end

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      tests++;
      fails++;
      $display("FAIL %s: got no instr_valid expected instr_valid within 100 cycles", name);
    end
  endtask

  // Wait for the held instruction, then retire it with the given decode.
  task automatic do_exec(input logic br, input logic tk, input logic jal, input logic jalr,
                         input logic [31:0] im, input logic [31:0] rs1,
                         input logic [31:0] nxt, input bit fetch_next);
    wait_valid("exec_wait");
    if (fetch_next) begin
      exp_fetch.push_back(nxt);
      exp_instr.push_back({nxt, mread(nxt)});
    end
    is_branch = br; taken = tk; is_jal = jal; is_jalr = jalr;
    imm = im; rs1_val = rs1; exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0; is_branch = 1'b0; taken = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    imm = '0; rs1_val = '0;
  endtask

  initial begin : stimulus
    int n;
    rst_n = 1'b0; exec_done = 1'b0; taken = 1'b0; is_branch = 1'b0;
    is_jal = 1'b0; is_jalr = 1'b0; imm = '0; rs1_val = '0;
    mem[32'h0] = 32'h0050_0093;

    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);

    exp_fetch.push_back(32'h0);
    exp_instr.push_back({32'h0, 32'h0050_0093});
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_first_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    chk("zero_lat_valid", {31'd0, instr_valid}, 32'd1);
    chk("zero_lat_instr", instr, 32'h0050_0093);

    gnt_lat = 3; rv_lat = 2;
    do_exec(0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 1);
    gnt_lat = 1; rv_lat = 1;
    do_exec(0, 0, 1, 0, 32'h0000_00FC, 32'h0, 32'h100, 1);
    gnt_lat = 0; rv_lat = 0;
    do_exec(1, 1, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'hF8, 1);
    do_exec(0, 0, 0, 0, 32'h0, 32'h0, 32'hFC, 1);
    do_exec(0, 0, 0, 0, 32'h0, 32'h0, 32'h100, 1);
    do_exec(1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h104, 1);
    do_exec(0, 0, 1, 1, 32'h4, 32'h0000_2001, 32'h2004, 1);
    chk("jalr_no_misalign", {31'd0, misalign}, 32'd0);
    do_exec(0, 0, 0, 1, 32'hC, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 1);
    do_exec(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    do_exec(0, 0, 1, 0, 32'h40, 32'h0, 32'h40, 1);
    do_exec(0, 0, 1, 0, 32'h6, 32'h0, 32'h0, 0);

    chk("halt_misalign", {31'd0, misalign}, 32'd1);
    chk("halt_pc", pc, 32'h40);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("halt_no_req", {31'd0, imem_req}, 32'd0);
    end
    chk("halt_sticky", {31'd0, misalign}, 32'd1);

    rst_n = 1'b0;
    #1;
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_misalign", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    gnt_lat = 0; rv_lat = 4;
    exp_fetch.push_back(32'h0);
    rst_n = 1'b1;
    n = 0;
    while (!imem_gnt && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_gnt_seen", {31'd0, imem_gnt}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("late_rvalid_instr", instr, 32'h0000_0013);
    chk("late_rvalid_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_rvalid_req", {31'd0, imem_req}, 32'd0);

    rv_lat = 0;
    exp_fetch.push_back(32'h0);
    exp_instr.push_back({32'h0, 32'h0050_0093});
    rst_n = 1'b1;
    wait_valid("restart_wait");
    repeat (2) @(negedge clk);
    chk("fetch_queue_empty", exp_fetch.size(), 32'd0);
    chk("instr_queue_empty", exp_instr.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
